alu: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_div.sv | 59 +++++
 rtl/alu.sv | 83 ++++++++
 tb/tb_alu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width and opcode encoding for the RV32IM execute-stage ALU.
//   XLEN      operand/result width (only 32 is supported)
//   alu_op_t  4-bit opcode; all 16 codes are defined
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_SLT    = 4'd8,
    OP_SLTU   = 4'd9,
    OP_MUL    = 4'd10,
    OP_MULH   = 4'd11,
    OP_MULHSU = 4'd12,
    OP_MULHU  = 4'd13,
    OP_DIV    = 4'd14,
    OP_REM    = 4'd15
  } alu_op_t;

endpackage

// File: rtl/alu_div.sv
// alu_div: combinational signed divider for DIV/REM.
//   dividend   in   XLEN  signed dividend (rs1)
//   divisor    in   XLEN  signed divisor (rs2)
//   quotient   out  XLEN  quotient truncated toward zero
//   remainder  out  XLEN  remainder carrying the sign of the dividend
// Divide-by-zero gives quotient all-ones and remainder = dividend; the
// most-negative / -1 overflow gives quotient = dividend and remainder 0.
module alu_div
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] b_safe;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic            q_neg;
  logic            r_neg;

  assign div_by_zero = (divisor == '0);
  assign overflow    = (dividend == MOST_NEG) && (divisor == '1);

  // Work on magnitudes with an unsigned divider, then restore signs. The
  // magnitude of MOST_NEG is 2^31, which still fits as an unsigned value.
  assign a_mag = dividend[XLEN-1] ? -dividend : dividend;
  assign b_mag = divisor[XLEN-1]  ? -divisor  : divisor;

  // Keeps the divider operand non-zero so the unused quotient never goes X.
  assign b_safe = div_by_zero ? XLEN'(1) : b_mag;

  assign q_mag = a_mag / b_safe;
  assign r_mag = a_mag % b_safe;
  assign q_neg = dividend[XLEN-1] ^ divisor[XLEN-1];
  assign r_neg = dividend[XLEN-1];

  // NOTE: every variable written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    quotient  = q_neg ? -q_mag : q_mag;
    remainder = r_neg ? -r_mag : r_mag;
    if (div_by_zero) begin
      quotient  = '1;
      remainder = dividend;
    end else if (overflow) begin
      quotient  = MOST_NEG;
      remainder = '0;
    end
  end

endmodule

// File: rtl/alu.sv
// alu: 32-bit RV32IM integer ALU with a registered result copy.
//   clk           in   1     rising-edge clock (ResultQ only)
//   rst_n         in   1     asynchronous active-low reset (ResultQ only)
//   InputA        in   XLEN  operand A (rs1)
//   InputB        in   XLEN  operand B (rs2/imm); shift amount is InputB[4:0]
//   AluOperation  in   4     opcode, encoded as alu_op_t
//   Result        out  XLEN  combinational result, zero latency
//   ResultQ       out  XLEN  Result captured on every rising clock edge
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] InputA,
  input  logic [XLEN-1:0] InputB,
  input  logic [3:0]      AluOperation,
  output logic [XLEN-1:0] Result,
  output logic [XLEN-1:0] ResultQ
);

  alu_op_t                op;
  logic [4:0]             shamt;
  logic                   a_signed;
  logic                   b_signed;
  logic signed [XLEN:0]   mul_a;
  logic signed [XLEN:0]   mul_b;
  logic signed [2*XLEN-1:0] product;
  logic [XLEN-1:0]        quotient;
  logic [XLEN-1:0]        remainder;

  assign op    = alu_op_t'(AluOperation);
  assign shamt = InputB[4:0];

  // One shared 33x33 signed multiplier. Each operand gets a 33rd bit that is
  // its sign for signed operands and 0 for unsigned ones, so MULHU and the
  // unsigned half of MULHSU come out of the same signed array.
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_signed = (op == OP_MULH);
  assign mul_a    = {a_signed & InputA[XLEN-1], InputA};
  assign mul_b    = {b_signed & InputB[XLEN-1], InputB};

  // The top two bits of the full 66-bit product are never selected, so the
  // product is formed directly at 64 bits (operands sign-extended first).
  assign product = 64'(mul_a) * 64'(mul_b);

  alu_div u_div (
    .dividend  (InputA),
    .divisor   (InputB),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    Result = '0;
    case (op)
      OP_ADD:    Result = InputA + InputB;
      OP_SUB:    Result = InputA - InputB;
      OP_AND:    Result = InputA & InputB;
      OP_OR:     Result = InputA | InputB;
      OP_XOR:    Result = InputA ^ InputB;
      OP_SLL:    Result = InputA << shamt;
      OP_SRL:    Result = InputA >> shamt;
      OP_SRA:    Result = $unsigned($signed(InputA) >>> shamt);
      OP_SLT:    Result = {{(XLEN-1){1'b0}}, $signed(InputA) < $signed(InputB)};
      OP_SLTU:   Result = {{(XLEN-1){1'b0}}, InputA < InputB};
      OP_MUL:    Result = product[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  Result = product[2*XLEN-1:XLEN];
      OP_DIV:    Result = quotient;
      OP_REM:    Result = remainder;
      default:   Result = '0;
    endcase
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ResultQ <= '0;
    else        ResultQ <= Result;
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] InputA;
  logic [31:0] InputB;
  logic [3:0]  AluOperation;
  logic [31:0] Result;
  logic [31:0] ResultQ;

  int          n_vec;
  int          n_err;
  logic [31:0] sb[$];

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .InputA       (InputA),
    .InputB       (InputB),
    .AluOperation (AluOperation),
    .Result       (Result),
    .ResultQ      (ResultQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the randomised back-to-back run.
  function automatic logic [31:0] model(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SRA:  return 32'(sa >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n        = 1'b0;
    AluOperation = OP_ADD;
    InputA       = 32'd5;
    InputB       = 32'd3;
    #2;
    n_vec++;
    if (Result !== 32'd8) begin
      n_err++;
      $display("FAIL reset_result got %h expected %h", Result, 32'd8);
    end
    n_vec++;
    if (ResultQ !== 32'd0) begin
      n_err++;
      $display("FAIL reset_q got %h expected %h", ResultQ, 32'd0);
    end
    @(posedge clk); #1;
    n_vec++;
    if (ResultQ !== 32'd0) begin
      n_err++;
      $display("FAIL reset_q_held got %h expected %h", ResultQ, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(32'd8);
    @(posedge clk); #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL reset_release scoreboard empty");
    end else if (ResultQ !== sb[0]) begin
      n_err++;
      $display("FAIL reset_release got %h expected %h", ResultQ, sb.pop_front());
    end else void'(sb.pop_front());
  endtask

  task automatic test_basic();
    vec_t tbl[13];
    tbl = '{
      '{OP_ADD,  32'd5,        32'd3,        32'd8},
      '{OP_SUB,  32'd8,        32'd3,        32'd5},
      '{OP_AND,  32'h0F,       32'hF0,       32'h0},
      '{OP_OR,   32'h0F,       32'hF0,       32'hFF},
      '{OP_XOR,  32'h0F,       32'hF0,       32'hFF},
      '{OP_SLT,  32'd3,        32'd5,        32'd1},
      '{OP_SLTU, 32'd3,        32'd5,        32'd1},
      '{OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1},
      '{OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0},
      '{OP_SLL,  32'd1,        32'd2,        32'd4},
      '{OP_SRL,  32'd4,        32'd2,        32'd1},
      '{OP_SRA,  32'h80000000, 32'd2,        32'hE0000000},
      '{OP_SLL,  32'd1,        32'h21,       32'd2}
    };
    foreach (tbl[i]) begin
      @(negedge clk);
      AluOperation = tbl[i].op;
      InputA       = tbl[i].a;
      InputB       = tbl[i].b;
      sb.push_back(tbl[i].exp);
      #1;
      n_vec++;
      if (Result !== tbl[i].exp) begin
        n_err++;
        $display("FAIL basic[%0d] %s Result got %h expected %h", i, tbl[i].op.name(), Result, tbl[i].exp);
      end
      @(posedge clk); #1;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL basic_q[%0d] scoreboard empty", i);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (ResultQ !== e) begin
          n_err++;
          $display("FAIL basic_q[%0d] ResultQ got %h expected %h", i, ResultQ, e);
        end
      end
    end
  endtask

  task automatic test_mul();
    vec_t tbl[9];
    tbl = '{
      '{OP_MUL,    32'd3,        32'd5,        32'h0000000F},
      '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000},
      '{OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000},
      '{OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000},
      '{OP_MULHSU, 32'd7,        32'h7FFFFFFF, 32'h00000003},
      '{OP_MULHSU, 32'hFFFFFFF9, 32'h0000000F, 32'hFFFFFFFF},
      '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{OP_MULHSU, 32'h7FFFFFFF, 32'h80000000, 32'h3FFFFFFF},
      '{OP_MULHSU, 32'd0,        32'hFFFFFFFF, 32'h00000000}
    };
    foreach (tbl[i]) begin
      @(negedge clk);
      AluOperation = tbl[i].op;
      InputA       = tbl[i].a;
      InputB       = tbl[i].b;
      sb.push_back(tbl[i].exp);
      #1;
      n_vec++;
      if (Result !== tbl[i].exp) begin
        n_err++;
        $display("FAIL mul[%0d] %s Result got %h expected %h", i, tbl[i].op.name(), Result, tbl[i].exp);
      end
      @(posedge clk); #1;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL mul_q[%0d] scoreboard empty", i);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (ResultQ !== e) begin
          n_err++;
          $display("FAIL mul_q[%0d] ResultQ got %h expected %h", i, ResultQ, e);
        end
      end
    end
  endtask

  task automatic test_div();
    vec_t tbl[10];
    tbl = '{
      '{OP_DIV, 32'd8,        32'd2,        32'd4},
      '{OP_REM, 32'd8,        32'd3,        32'd2},
      '{OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
      '{OP_REM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
      '{OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD},
      '{OP_REM, 32'd7,        32'hFFFFFFFE, 32'd1},
      '{OP_DIV, 32'h00001234, 32'd0,        32'hFFFFFFFF},
      '{OP_REM, 32'd8,        32'd0,        32'd8},
      '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0}
    };
    foreach (tbl[i]) begin
      @(negedge clk);
      AluOperation = tbl[i].op;
      InputA       = tbl[i].a;
      InputB       = tbl[i].b;
      sb.push_back(tbl[i].exp);
      #1;
      n_vec++;
      if (Result !== tbl[i].exp) begin
        n_err++;
        $display("FAIL div[%0d] %s Result got %h expected %h", i, tbl[i].op.name(), Result, tbl[i].exp);
      end
      @(posedge clk); #1;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL div_q[%0d] scoreboard empty", i);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (ResultQ !== e) begin
          n_err++;
          $display("FAIL div_q[%0d] ResultQ got %h expected %h", i, ResultQ, e);
        end
      end
    end
  endtask

  // A new random operation every cycle; ResultQ must track with latency 1.
  task automatic test_back_to_back();
    alu_op_t op;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 4))
        0:       op = OP_ADD;
        1:       op = OP_SUB;
        2:       op = OP_XOR;
        3:       op = OP_SLTU;
        default: op = OP_SRA;
      endcase
      AluOperation = op;
      InputA       = $urandom();
      InputB       = $urandom();
      sb.push_back(model(op, InputA, InputB));
      @(posedge clk); #1;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL b2b[%0d] scoreboard empty", i);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (ResultQ !== e) begin
          n_err++;
          $display("FAIL b2b[%0d] %s ResultQ got %h expected %h", i, op.name(), ResultQ, e);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_mul();
    test_div();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
